// File: rtl/stepper_pio_in_debounced.sv
// Avalon-MM input PIO: per-bit 2-FF synchroniser, debounce counter, rise/fall edge capture
// with write-1-to-clear and a masked level interrupt.
module stepper_pio_in_debounced #(
  parameter int WIDTH           = 9,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] capture_next;
  logic [31:0]      read_next;
  logic             write_en;

  assign write_en = chipselect & ~write_n;
  assign wdata    = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata_bits;
      assign unused_wdata_bits = ^writedata[31:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db_d  <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      db_d  <= db;
    end
  end

  // Each bit owns its counter; a new level is accepted only after DEBOUNCE_CYCLES
  // consecutive mismatching samples, and any return to the old level restarts the count.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_db
      logic [CNT_W-1:0] cnt;
      logic             db_bit;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt    <= '0;
          db_bit <= 1'b0;
        end else if (sync2[gi] == db_bit) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          db_bit <= sync2[gi];
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign db[gi] = db_bit;
    end
  endgenerate

  assign rise = db & ~db_d & rise_en;
  assign fall = ~db & db_d & fall_en;

  // New events are OR-ed in after the clear so a coincident clear cannot drop them.
  always_comb begin
    capture_next = edge_capture;
    if (write_en && address == 3'd3) begin
      capture_next = edge_capture & ~wdata;
    end
    capture_next = capture_next | rise | fall;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      rise_en      <= '1;
      fall_en      <= '0;
      edge_capture <= '0;
    end else begin
      edge_capture <= capture_next;
      if (write_en) begin
        case (address)
          3'd2:    irq_mask <= wdata;
          3'd4:    rise_en  <= wdata;
          3'd5:    fall_en  <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    read_next = '0;
    case (address)
      3'd0:    read_next = 32'(db);
      3'd1:    read_next = 32'(sync2);
      3'd2:    read_next = 32'(irq_mask);
      3'd3:    read_next = 32'(edge_capture);
      3'd4:    read_next = 32'(rise_en);
      3'd5:    read_next = 32'(fall_en);
      default: read_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= read_next;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_stepper_pio_in_debounced.sv
// Self-checking bench for stepper_pio_in_debounced with WIDTH=9, DEBOUNCE_CYCLES=4:
// register reads are scoreboarded through a queue of expected values.
module tb_stepper_pio_in_debounced;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [8:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  logic [31:0] exp_q[$];
  logic [31:0] rd_data;
  logic [31:0] exp_v;
  int          n_cmp;
  int          n_err;

  stepper_pio_in_debounced #(
    .WIDTH(9),
    .CNT_W(16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("wr addr=%0d data=%h", a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    address = a;
    tick();
    rd_data = readdata;
    $display("rd addr=%0d data=%h", a, rd_data);
  endtask

  task automatic test_reset();
    logic [31:0] exp_rst [5];
    logic [2:0]  addr_rst [5];
    exp_rst  = '{32'h000, 32'h000, 32'h000, 32'h1FF, 32'h000};
    addr_rst = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
    reset_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: readdata=%h irq=%b want 0/0", readdata, irq);
    end
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exp_rst[i]);
      rd(addr_rst[i]);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (rd_data !== exp_v) begin
        n_err++;
        $display("FAIL reset_reg%0d: got %h want %h", addr_rst[i], rd_data, exp_v);
      end
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_debounce();
    in_port[0] = 1'b1;
    repeat (3) tick();
    in_port[0] = 1'b0;
    repeat (10) tick();
    exp_q.push_back(32'h000);
    rd(3'd0);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL glitch_data: got %h want %h", rd_data, exp_v);
    end
    exp_q.push_back(32'h000);
    rd(3'd3);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL glitch_edge: got %h want %h", rd_data, exp_v);
    end
    // db changes at edge 6; readdata shows it one edge later
    address = 3'd0;
    tick();
    in_port[0] = 1'b1;
    exp_q.push_back(32'h000);
    exp_q.push_back(32'h001);
    repeat (6) tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (readdata !== exp_v) begin
      n_err++;
      $display("FAIL latency_early: got %h want %h", readdata, exp_v);
    end
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (readdata !== exp_v) begin
      n_err++;
      $display("FAIL latency_data: got %h want %h", readdata, exp_v);
    end
    exp_q.push_back(32'h001);
    rd(3'd3);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL rise_capture: got %h want %h", rd_data, exp_v);
    end
  endtask

  task automatic test_irq_w1c();
    wr(3'd2, 32'h001);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_set: got %b want 1", irq);
    end
    wr(3'd3, 32'h000);
    exp_q.push_back(32'h001);
    rd(3'd3);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL w1c_zero: got %h want %h", rd_data, exp_v);
    end
    wr(3'd3, 32'h001);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear: got %b want 0", irq);
    end
    exp_q.push_back(32'h000);
    rd(3'd3);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL w1c_one: got %h want %h", rd_data, exp_v);
    end
    // write without chipselect must be ignored
    address    = 3'd2;
    writedata  = 32'h1FF;
    write_n    = 1'b0;
    tick();
    write_n    = 1'b1;
    exp_q.push_back(32'h001);
    rd(3'd2);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL cs_ignored: got %h want %h", rd_data, exp_v);
    end
  endtask

  task automatic test_edge_select();
    wr(3'd4, 32'h000);
    wr(3'd5, 32'h100);
    in_port[8] = 1'b1;
    repeat (10) tick();
    exp_q.push_back(32'h000);
    rd(3'd3);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL rise_disabled: got %h want %h", rd_data, exp_v);
    end
    exp_q.push_back(32'h101);
    rd(3'd1);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL raw_read: got %h want %h", rd_data, exp_v);
    end
    exp_q.push_back(32'h101);
    rd(3'd0);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL data_read: got %h want %h", rd_data, exp_v);
    end
    in_port[8] = 1'b0;
    repeat (10) tick();
    exp_q.push_back(32'h100);
    rd(3'd3);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL fall_capture: got %h want %h", rd_data, exp_v);
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_masked: got %b want 0", irq);
    end
    wr(3'd3, 32'h100);
    wr(3'd6, 32'hFFFF_FFFF);
    exp_q.push_back(32'h000);
    exp_q.push_back(32'h000);
    rd(3'd6);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL addr6_read: got %h want %h", rd_data, exp_v);
    end
    rd(3'd7);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL addr7_read: got %h want %h", rd_data, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    wr(3'd4, 32'h004);
    in_port[2] = 1'b1;
    repeat (6) tick();
    // clear lands on edge 7, the same edge the bit-2 capture sets
    wr(3'd3, 32'h004);
    exp_q.push_back(32'h004);
    rd(3'd3);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL set_wins: got %h want %h", rd_data, exp_v);
    end
    wr(3'd3, 32'h004);
    exp_q.push_back(32'h000);
    rd(3'd3);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL later_clear: got %h want %h", rd_data, exp_v);
    end
  endtask

  task automatic test_reset_mid_debounce();
    wr(3'd5, 32'h004);
    in_port[2] = 1'b0;
    repeat (10) tick();
    wr(3'd2, 32'h1FF);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_irq: got %b want 1", irq);
    end
    address    = 3'd4;
    in_port[5] = 1'b1;
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: readdata=%h irq=%b want 0/0", readdata, irq);
    end
    tick();
    tick();
    reset_n = 1'b1;
    address = 3'd0;
    exp_q.push_back(32'h000);
    exp_q.push_back(32'h021);
    repeat (6) tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (readdata !== exp_v) begin
      n_err++;
      $display("FAIL restart_early: got %h want %h", readdata, exp_v);
    end
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (readdata !== exp_v) begin
      n_err++;
      $display("FAIL restart_data: got %h want %h", readdata, exp_v);
    end
    exp_q.push_back(32'h1FF);
    exp_q.push_back(32'h000);
    exp_q.push_back(32'h021);
    rd(3'd4);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL post_rise_en: got %h want %h", rd_data, exp_v);
    end
    rd(3'd2);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL post_mask: got %h want %h", rd_data, exp_v);
    end
    rd(3'd3);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd_data !== exp_v) begin
      n_err++;
      $display("FAIL post_edge: got %h want %h", rd_data, exp_v);
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL post_irq: got %b want 0", irq);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 9'h000;
    test_reset();
    test_debounce();
    test_irq_w1c();
    test_edge_select();
    test_back_to_back();
    test_reset_mid_debounce();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
